spi_cmd_ctrl: RTL and testbench

//  Byte-level command controller between SPI_Slave's byte interface and a simple register bus.

---
 rtl/spi_cmd_ctrl_if.sv | 23 ++
 rtl/spi_cmd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_ctrl_if.sv
// Register-bus interface between spi_cmd_ctrl (master) and a simple register block (slave).
// Handshake: master raises bus_we or bus_re with bus_addr/bus_wdata stable and holds them
// until the cycle in which the slave pulses bus_ack; bus_rdata is valid in that cycle.
interface spi_cmd_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [7:0]            bus_wdata;
    logic                  bus_we;
    logic                  bus_re;
    logic [7:0]            bus_rdata;
    logic                  bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// SPI byte-stream command parser (WRITE/READ/ID) driving a register bus; read data is
// returned in the next CS frame. Optional bus timeout enabled by SPI_CTRL_TIMEOUT_EN.
module spi_cmd_ctrl #(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] DEVICE_ID      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    spi_cmd_ctrl_if.master    bus,
    input  logic              clr_err,
    output logic [2:0]        err_flags,
    output logic              frame_active,
    output logic [3:0]        state_dbg
);
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_ID    = 8'h9F;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_BUS_WR, S_SKIP, S_FIN, S_BUS_RD, S_LOAD_TX
    } state_t;

    state_t state, state_nx;

    // CS resets high (inactive) so a reset release never looks like a frame start.
    logic cs_s1, cs_s2;
    logic rv_s1, rv_s2, rv_d;
    logic byte_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1 <= 1'b1;
            cs_s2 <= 1'b1;
            rv_s1 <= 1'b0;
            rv_s2 <= 1'b0;
            rv_d  <= 1'b0;
        end else begin
            cs_s1 <= spi_cs;
            cs_s2 <= cs_s1;
            rv_s1 <= rx_valid;
            rv_s2 <= rv_s1;
            rv_d  <= rv_s2;
        end
    end

    assign byte_ev      = rv_s2 & ~rv_d;
    assign frame_active = ~cs_s2;

    logic [7:0]            cmd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  addr_ok;
    logic [7:0]            wdata_q;
    logic [7:0]            tx_q;
    logic [2:0]            err_q;
    logic [ADDR_WIDTH-1:0] addr_byte;
    logic                  bus_busy;
    logic                  tmo_hit;
    logic                  bus_done;
    logic [2:0]            err_set;

    if (ADDR_WIDTH > 8) begin : g_addr_ext
        assign addr_byte = {{(ADDR_WIDTH-8){1'b0}}, rx_data};
    end else if (ADDR_WIDTH == 8) begin : g_addr_eq
        assign addr_byte = rx_data;
    end else begin : g_addr_trunc
        assign addr_byte = rx_data[ADDR_WIDTH-1:0];
    end

    assign bus_busy = (state == S_BUS_WR) || (state == S_BUS_RD);
    assign bus_done = bus.bus_ack || tmo_hit;

`ifdef SPI_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if (bus_busy && !bus.bus_ack && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end

    assign tmo_hit = bus_busy && !bus.bus_ack && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Frame end is tested as the synced CS level after any byte in the same cycle,
    // so a final byte coinciding with CS rise is still parsed.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (!cs_s2) state_nx = S_CMD;
            S_CMD: begin
                if (byte_ev)
                    state_nx = (rx_data == CMD_WRITE || rx_data == CMD_READ) ? S_ADDR : S_SKIP;
                if (cs_s2) state_nx = S_FIN;
            end
            S_ADDR: begin
                if (byte_ev) state_nx = (cmd_q == CMD_WRITE) ? S_WDATA : S_SKIP;
                if (cs_s2)   state_nx = S_FIN;
            end
            S_WDATA: begin
                if (byte_ev)    state_nx = S_BUS_WR;
                else if (cs_s2) state_nx = S_FIN;
            end
            S_SKIP:    if (cs_s2) state_nx = S_FIN;
            S_BUS_WR:  if (bus_done) state_nx = cs_s2 ? S_FIN : S_WDATA;
            S_FIN: begin
                if (cmd_q == CMD_READ && addr_ok) state_nx = S_BUS_RD;
                else if (cmd_q == CMD_ID)         state_nx = S_LOAD_TX;
                else                              state_nx = S_IDLE;
            end
            S_BUS_RD:  if (bus_done) state_nx = S_LOAD_TX;
            S_LOAD_TX: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            addr_q  <= '0;
            addr_ok <= 1'b0;
            wdata_q <= '0;
            tx_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (!cs_s2) begin
                    cmd_q   <= '0;
                    addr_ok <= 1'b0;
                end
                S_CMD:    if (byte_ev) cmd_q <= rx_data;
                S_ADDR: if (byte_ev) begin
                    addr_q  <= addr_byte;
                    addr_ok <= 1'b1;
                end
                S_WDATA:  if (byte_ev) wdata_q <= rx_data;
                S_BUS_WR: if (bus_done) addr_q <= addr_q + 1'b1;
                S_FIN:    if (cmd_q == CMD_ID) tx_q <= DEVICE_ID;
                S_BUS_RD: begin
                    if (bus.bus_ack)  tx_q <= bus.bus_rdata;
                    else if (tmo_hit) tx_q <= 8'hFF;
                end
                default: ;
            endcase
        end
    end

    assign err_set[0] = (state == S_BUS_WR) && byte_ev;
    assign err_set[1] = (state == S_LOAD_TX) && !cs_s2;
    assign err_set[2] = tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= (err_q & ~{3{clr_err}}) | err_set;
    end

    assign err_flags     = err_q;
    assign tx_valid      = (state == S_LOAD_TX) && cs_s2;
    assign tx_data       = tx_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_we    = (state == S_BUS_WR);
    assign bus.bus_re    = (state == S_BUS_RD);
    assign state_dbg     = state;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed frames plus random frames checked against a
// frame-level reference model of the command protocol and a bus memory model.
module tb_spi_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_cs;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       clr_err;
    logic [2:0] err_flags;
    logic       frame_active;
    logic [3:0] state_dbg;

    spi_cmd_ctrl_if #(.ADDR_WIDTH(8)) bus_if ();

    spi_cmd_ctrl #(.ADDR_WIDTH(8), .DEVICE_ID(8'hA5), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .bus(bus_if), .clr_err(clr_err),
        .err_flags(err_flags), .frame_active(frame_active), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  frame_q [$];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  exp_tx_q [$];
    logic [15:0] got_wr_q [$];
    logic [7:0]  got_rd_q [$];
    logic [7:0]  got_tx_q [$];
    int          ack_delay = 0;
    bit          ack_hold  = 1'b0;
    int          both_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus slave: acks after ack_delay cycles of request; logs transactions; tx monitor.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            bus_if.bus_ack = 1'b0;
            if (bus_if.bus_we && bus_if.bus_re) both_cnt++;
            if (tx_valid) got_tx_q.push_back(tx_data);
            if ((bus_if.bus_we || bus_if.bus_re) && !ack_hold) begin
                if (wait_cnt >= ack_delay) begin
                    bus_if.bus_ack = 1'b1;
                    wait_cnt = 0;
                    if (bus_if.bus_we) begin
                        mem[bus_if.bus_addr] = bus_if.bus_wdata;
                        got_wr_q.push_back({bus_if.bus_addr, bus_if.bus_wdata});
                    end else begin
                        bus_if.bus_rdata = mem[bus_if.bus_addr];
                        got_rd_q.push_back(bus_if.bus_addr);
                    end
                end else begin
                    wait_cnt++;
                end
            end else if (!(bus_if.bus_we || bus_if.bus_re)) begin
                wait_cnt = 0;
            end
        end
    end

    // Frame-level protocol model: what a frame of bytes must do on the bus and on tx.
    function automatic void model_frame();
        logic [7:0] a;
        if (frame_q.size() == 0) return;
        case (frame_q[0])
            8'h01: if (frame_q.size() >= 2) begin
                a = frame_q[1];
                for (int i = 2; i < frame_q.size(); i++) begin
                    exp_wr_q.push_back({a, frame_q[i]});
                    ref_mem[a] = frame_q[i];
                    a = a + 8'd1;
                end
            end
            8'h02: if (frame_q.size() >= 2) begin
                exp_rd_q.push_back(frame_q[1]);
                exp_tx_q.push_back(ref_mem[frame_q[1]]);
            end
            8'h9F: exp_tx_q.push_back(8'hA5);
            default: ;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        foreach (frame_q[i]) send_byte(frame_q[i]);
        spi_cs = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_wr_cnt"}, got_wr_q.size(), exp_wr_q.size());
        while (got_wr_q.size() > 0 && exp_wr_q.size() > 0)
            check({tag, "_wr"}, got_wr_q.pop_front(), exp_wr_q.pop_front());
        check({tag, "_rd_cnt"}, got_rd_q.size(), exp_rd_q.size());
        while (got_rd_q.size() > 0 && exp_rd_q.size() > 0)
            check({tag, "_rd"}, got_rd_q.pop_front(), exp_rd_q.pop_front());
        check({tag, "_tx_cnt"}, got_tx_q.size(), exp_tx_q.size());
        while (got_tx_q.size() > 0 && exp_tx_q.size() > 0)
            check({tag, "_tx"}, got_tx_q.pop_front(), exp_tx_q.pop_front());
        got_wr_q.delete(); got_rd_q.delete(); got_tx_q.delete();
        exp_wr_q.delete(); exp_rd_q.delete(); exp_tx_q.delete();
    endtask

    task automatic run_model_frame(input string tag);
        model_frame();
        send_frame(30);
        check_results(tag);
        check({tag, "_err"}, err_flags, 3'b000);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; spi_cs = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clr_err = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h20] = 8'h5C;
        ref_mem[8'h20] = 8'h5C;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_bus_we", bus_if.bus_we, 1'b0);
        check("rst_bus_re", bus_if.bus_re, 1'b0);
        check("rst_bus_addr", bus_if.bus_addr, 8'h00);
        check("rst_err", err_flags, 3'b000);
        check("rst_frame_active", frame_active, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // frame_active follows CS low
        @(negedge clk); spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        check("frame_active_low", frame_active, 1'b1);
        spi_cs = 1'b1;
        repeat (6) @(negedge clk);
        check("frame_active_high", frame_active, 1'b0);
        check_results("empty_frame");

        frame_q = {8'h01, 8'h10, 8'hAA, 8'hBB};
        run_model_frame("write2");
        frame_q = {8'h02, 8'h20};
        run_model_frame("read20");
        frame_q = {8'h9F};
        run_model_frame("id");
        frame_q = {8'h01, 8'hFF, 8'h11, 8'h22};
        run_model_frame("wrap");
        frame_q = {8'h01};
        run_model_frame("cmd_only");
        frame_q = {8'h02};
        run_model_frame("read_noaddr");

        for (int n = 0; n < 24; n++) begin
            int len;
            int kind;
            frame_q.delete();
            len  = $urandom_range(0, 5);
            kind = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
            if (len > 0) begin
                case (kind)
                    0: frame_q[0] = 8'h01;
                    1: frame_q[0] = 8'h02;
                    2: frame_q[0] = 8'h9F;
                    default: ;
                endcase
            end
            ack_delay = $urandom_range(0, 3);
            run_model_frame("rand");
        end
        ack_delay = 0;

        // Overrun: ack delayed past the next byte
        ack_delay = 20;
        frame_q = {8'h01, 8'h40, 8'hAA, 8'hBB};
        send_frame(40);
        exp_wr_q.push_back({8'h40, 8'hAA});
        ref_mem[8'h40] = 8'hAA;
        check_results("overrun");
        check("overrun_err", err_flags, 3'b001);
        pulse_clr();
        check("overrun_clr", err_flags, 3'b000);
        ack_delay = 0;

        // Late: CS re-falls before the read result can be loaded
        ack_hold = 1'b1;
        frame_q = {8'h02, 8'h20};
        send_frame(10);
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        ack_hold = 1'b0;
        repeat (6) @(negedge clk);
        exp_rd_q.push_back(8'h20);
        check_results("late");
        check("late_err", err_flags, 3'b010);
        send_byte(8'h9F);
        spi_cs = 1'b1;
        repeat (30) @(negedge clk);
        exp_tx_q.push_back(8'hA5);
        check_results("after_late");
        pulse_clr();
        check("late_clr", err_flags, 3'b000);

`ifdef SPI_CTRL_TIMEOUT_EN
        ack_hold = 1'b1;
        frame_q = {8'h02, 8'h21};
        send_frame(300);
        exp_tx_q.push_back(8'hFF);
        check_results("timeout");
        check("timeout_err", err_flags, 3'b100);
        ack_hold = 1'b0;
        pulse_clr();
`endif

        // Reset in the middle of a bus write
        ack_hold = 1'b1;
        @(negedge clk); spi_cs = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'h01); send_byte(8'h30); send_byte(8'h77);
        check("we_before_rst", bus_if.bus_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_abort_we", bus_if.bus_we, 1'b0);
        check("rst_abort_re", bus_if.bus_re, 1'b0);
        check("rst_abort_tx", tx_valid, 1'b0);
        spi_cs = 1'b1;
        ack_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_results("post_rst");
        check("both_req", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
